accel_run_ctrl: RTL and testbench
=================================

# accel_run_ctrl

Parametrised run controller for the systolic-array accelerator top level. It arms on a start request and walks the row, column and inner-loop tile indices, advancing one inner step per datapath step strobe. After the last step it flushes the pipeline, then raises done/finished flags and captures performance counters. All loop bounds are generics, so the block serves any tiling, replacing fixed index-compare finish logic.

## Interface
Parameters:
- ROW_TILES, 8, number of row tiles (≥1)
- COL_TILES, 25, number of column tiles (≥1)
- INNER_ITERS, 32, inner-loop iterations per tile (≥1)
- DRAIN_CYCLES, 16, pipeline flush cycles after the last step (≥1)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request (button level); a rising edge arms a run
- abort  in  1  synchronous abort of the current run
- step_valid  in  1  datapath completed one inner-loop step this cycle
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on run completion
- finished  out  1  sticky completion flag (LED)
- tile_row_idx  out  $clog2(ROW_TILES) (min 1)  current row tile
- tile_col_idx  out  $clog2(COL_TILES) (min 1)  current column tile
- inner_idx  out  $clog2(INNER_ITERS) (min 1)  current inner iteration
- cycle_count  out  CNT_W  cycles elapsed in the current or last run
- saved_cycles  out  CNT_W  cycle_count captured at the last completion
- stall_cycles  out  CNT_W  RUN cycles without step_valid
- run_count  out  8  completed runs, wrapping

## Operation
- States: IDLE, RUN, DRAIN, DONE. All outputs reset to 0; state resets to IDLE.
- A start edge is detected when start=1 and start_d=0. start_d is a registered copy of start, reset to 0.
- IDLE or DONE with a start edge → RUN.
  - Indices, cycle_count and stall_cycles clear to 0.
  - finished clears.
- Start edges in RUN or DRAIN are ignored.
- RUN, on step_valid:
  - inner_idx increments; it wraps to 0 at INNER_ITERS-1 and carries into tile_col_idx.
  - tile_col_idx wraps to 0 at COL_TILES-1 and carries into tile_row_idx.
- A step_valid with all indices at their maximum is the last step → DRAIN.
  - Indices hold their maximum values through DRAIN and DONE.
- DRAIN counts DRAIN_CYCLES cycles, then → DONE.
- On entry to DONE, in that same cycle:
  - done pulses.
  - finished sets.
  - saved_cycles ← final cycle_count.
  - run_count increments.
- cycle_count increments in every RUN and DRAIN cycle and saturates at all-ones.
- stall_cycles increments in RUN cycles with step_valid=0 and saturates.
- abort in RUN or DRAIN → IDLE next cycle.
  - No done pulse.
  - finished, saved_cycles and run_count are unchanged.
  - Indices and cycle_count hold their values.
- abort in IDLE or DONE is ignored.
- Simultaneous events:
  - abort and step_valid together: abort wins and the step is discarded.
  - abort and a start edge together in DONE: the start edge wins.
- step_valid outside RUN is ignored.

## Timing
- A start edge sampled at edge N puts the block in RUN from cycle N+1; busy rises at N+1.
- Index updates are registered: visible one cycle after the step_valid cycle.
- With step_valid held high, total steps S = ROW_TILES·COL_TILES·INNER_ITERS.
  - RUN lasts S cycles, DRAIN lasts DRAIN_CYCLES cycles.
  - saved_cycles = S + DRAIN_CYCLES.
- done is high exactly one cycle: the first DONE cycle. finished rises in that same cycle.
- Asynchronous reset mid-run returns the block to IDLE immediately with all outputs at 0.

## Configuration
- RUN_CTRL_STALL_CNT_EN:
  - Defined: the stall_cycles counter is built as described above.
  - Undefined: no counter register is built and stall_cycles is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package accel_pkg holds:
  - the state enum run_state_t (IDLE, RUN, DRAIN, DONE);
  - the CNT_W default;
  - a saturating-increment function.
- One sub-module, tile_idx_counter: a parametrised cascaded wrap counter (row/col/inner) with an advance input, a clear input and a last-step flag output.

## Test plan
Parameters for all scenarios: ROW_TILES=2, COL_TILES=3, INNER_ITERS=4, DRAIN_CYCLES=2.
- Start edge, step_valid held high → RUN for 24 cycles, DRAIN 2. Then done pulses once; saved_cycles=26, stall_cycles=0, run_count=1, finished=1, indices=(1,2,3).
- step_valid high every other cycle → RUN for 48 cycles, stall_cycles=24, saved_cycles=50.
- Abort asserted at step 10 together with step_valid → IDLE, no done pulse, inner_idx=1 (step discarded), run_count unchanged.
- Start edge in DONE → finished clears, counters clear, second run completes with run_count=2. Start held high through the run → no retrigger.
- Reset deasserted-then-asserted (rst low) mid-DRAIN → busy=0, all outputs 0 asynchronously, state IDLE.
- cycle_count saturation, run with CNT_W=4 → cycle_count and saved_cycles = 15. Build without RUN_CTRL_STALL_CNT_EN → stall_cycles stays 0.

Source files
------------

// File: rtl/accel_pkg.sv
// accel_pkg: shared run-state enum, counter width default and saturating increment.
package accel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} run_state_t;
  localparam int CNT_W_DEF = 32;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/tile_idx_counter.sv
// tile_idx_counter: cascaded row/col/inner wrap counter that holds at its final index.
module tile_idx_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 25,
  parameter int INNER = 32,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
  localparam int IW = INNER > 1 ? $clog2(INNER) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [IW-1:0] inner,
  output logic          last
);
  logic row_max, col_max, inner_max;
  assign row_max = row == RW'(ROWS - 1);
  assign col_max = col == CW'(COLS - 1);
  assign inner_max = inner == IW'(INNER - 1);
  assign last = row_max & col_max & inner_max;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row <= '0;
      col <= '0;
      inner <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      inner <= '0;
    end else if (adv && !last) begin
      inner <= inner_max ? '0 : inner + IW'(1);
      if (inner_max) col <= col_max ? '0 : col + CW'(1);
      if (inner_max && col_max) row <= row + RW'(1);
    end
endmodule

// File: rtl/accel_run_ctrl.sv
// accel_run_ctrl: tiled run controller with drain, completion flags and perf counters.
// Optional stall counter is built only when RUN_CTRL_STALL_CNT_EN is defined.
module accel_run_ctrl
  import accel_pkg::*;
#(
  parameter int ROW_TILES = 8,
  parameter int COL_TILES = 25,
  parameter int INNER_ITERS = 32,
  parameter int DRAIN_CYCLES = 16,
  parameter int CNT_W = CNT_W_DEF,
  localparam int RW = ROW_TILES > 1 ? $clog2(ROW_TILES) : 1,
  localparam int CW = COL_TILES > 1 ? $clog2(COL_TILES) : 1,
  localparam int IW = INNER_ITERS > 1 ? $clog2(INNER_ITERS) : 1,
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step_valid,
  output logic             busy,
  output logic             done,
  output logic             finished,
  output logic [RW-1:0]    tile_row_idx,
  output logic [CW-1:0]    tile_col_idx,
  output logic [IW-1:0]    inner_idx,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] saved_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [7:0]       run_count
);
  run_state_t state;
  logic start_d, clr, adv, last;
  logic [DW-1:0] drain_cnt;
  logic [CNT_W-1:0] cyc_inc;
  assign busy = (state == RUN) | (state == DRAIN);
  assign clr = start & ~start_d & ((state == IDLE) | (state == DONE));
  assign adv = (state == RUN) & step_valid & ~abort;
  assign cyc_inc = CNT_W'(sat_inc(64'(cycle_count), CNT_W));
  tile_idx_counter #(.ROWS(ROW_TILES), .COLS(COL_TILES), .INNER(INNER_ITERS)) u_idx (
    .clk(clk), .rst(rst), .clr(clr), .adv(adv),
    .row(tile_row_idx), .col(tile_col_idx), .inner(inner_idx), .last(last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      start_d <= 1'b0;
      done <= 1'b0;
      finished <= 1'b0;
      drain_cnt <= '0;
      cycle_count <= '0;
      saved_cycles <= '0;
      run_count <= '0;
    end else begin
      start_d <= start;
      done <= 1'b0;
      if (clr) begin
        state <= RUN;
        cycle_count <= '0;
        finished <= 1'b0;
      end else if (busy && abort) begin
        state <= IDLE;
      end else if (state == RUN) begin
        cycle_count <= cyc_inc;
        drain_cnt <= '0;
        if (step_valid && last) state <= DRAIN;
      end else if (state == DRAIN) begin
        cycle_count <= cyc_inc;
        drain_cnt <= drain_cnt + DW'(1);
        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
          state <= DONE;
          done <= 1'b1;
          finished <= 1'b1;
          saved_cycles <= cyc_inc;
          run_count <= run_count + 8'd1;
        end
      end
    end
`ifdef RUN_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cycles <= '0;
    else if (clr) stall_cycles <= '0;
    else if (state == RUN && !abort && !step_valid) stall_cycles <= CNT_W'(sat_inc(64'(stall_cycles), CNT_W));
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_accel_run_ctrl.sv
// tb_accel_run_ctrl: directed self-checking bench for accel_run_ctrl (2x3x4 tiling, drain 2).
module tb_accel_run_ctrl;
`ifdef RUN_CTRL_STALL_CNT_EN
  localparam int STALL_EXP = 24;
`else
  localparam int STALL_EXP = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, step_valid = 1'b0;
  logic busy, done, finished;
  logic [0:0] row;
  logic [1:0] col, inner;
  logic [31:0] cyc, saved, stall;
  logic [7:0] runs;
  logic b4_busy, b4_done, b4_finished;
  logic [0:0] b4_row;
  logic [1:0] b4_col, b4_inner;
  logic [3:0] b4_cyc, b4_saved, b4_stall;
  logic [7:0] b4_runs;
  int asserts = 0, fails = 0;
  accel_run_ctrl #(.ROW_TILES(2), .COL_TILES(3), .INNER_ITERS(4), .DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_valid(step_valid),
    .busy(busy), .done(done), .finished(finished), .tile_row_idx(row), .tile_col_idx(col),
    .inner_idx(inner), .cycle_count(cyc), .saved_cycles(saved), .stall_cycles(stall), .run_count(runs)
  );
  accel_run_ctrl #(.ROW_TILES(2), .COL_TILES(3), .INNER_ITERS(4), .DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_valid(step_valid),
    .busy(b4_busy), .done(b4_done), .finished(b4_finished), .tile_row_idx(b4_row), .tile_col_idx(b4_col),
    .inner_idx(b4_inner), .cycle_count(b4_cyc), .saved_cycles(b4_saved), .stall_cycles(b4_stall), .run_count(b4_runs)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #12;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0d want 0", busy); end
    asserts++; if (done !== 1'b0 || finished !== 1'b0) begin fails++; $display("FAIL rst_flags: got done=%0d fin=%0d want 0 0", done, finished); end
    asserts++; if (cyc !== 32'd0 || saved !== 32'd0 || stall !== 32'd0 || runs !== 8'd0) begin fails++; $display("FAIL rst_counters: got %0d %0d %0d %0d want 0 0 0 0", cyc, saved, stall, runs); end
    asserts++; if ({row, col, inner} !== 5'd0) begin fails++; $display("FAIL rst_idx: got %0d %0d %0d want 0 0 0", row, col, inner); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask
  task automatic test_full_run();
    int n;
    start = 1'b1;
    step_valid = 1'b1;
    tick();
    asserts++; if (busy !== 1'b1 || cyc !== 32'd0) begin fails++; $display("FAIL full_start: got busy=%0d cyc=%0d want 1 0", busy, cyc); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    asserts++; if (n != 26) begin fails++; $display("FAIL full_latency: got %0d cycles want 26", n); end
    asserts++; if (saved !== 32'd26 || cyc !== 32'd26) begin fails++; $display("FAIL full_saved: got saved=%0d cyc=%0d want 26 26", saved, cyc); end
    asserts++; if (stall !== 32'd0) begin fails++; $display("FAIL full_stall: got %0d want 0", stall); end
    asserts++; if (runs !== 8'd1 || finished !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL full_flags: got runs=%0d fin=%0d busy=%0d want 1 1 0", runs, finished, busy); end
    asserts++; if (row !== 1'd1 || col !== 2'd2 || inner !== 2'd3) begin fails++; $display("FAIL full_idx: got %0d %0d %0d want 1 2 3", row, col, inner); end
    asserts++; if (b4_cyc !== 4'd15 || b4_saved !== 4'd15) begin fails++; $display("FAIL sat_cnt: got cyc=%0d saved=%0d want 15 15", b4_cyc, b4_saved); end
    tick();
    asserts++; if (done !== 1'b0 || finished !== 1'b1) begin fails++; $display("FAIL full_done_pulse: got done=%0d fin=%0d want 0 1", done, finished); end
    start = 1'b0;
    step_valid = 1'b0;
    tick();
  endtask
  task automatic test_stall_pattern();
    int n;
    start = 1'b1;
    step_valid = 1'b0;
    tick();
    asserts++; if (busy !== 1'b1 || finished !== 1'b0 || cyc !== 32'd0 || {row, col, inner} !== 5'd0) begin fails++; $display("FAIL restart_clear: got busy=%0d fin=%0d cyc=%0d idx=%0d want 1 0 0 0", busy, finished, cyc, {row, col, inner}); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; step_valid = ~step_valid; end
    asserts++; if (n != 50) begin fails++; $display("FAIL stall_latency: got %0d cycles want 50", n); end
    asserts++; if (saved !== 32'd50) begin fails++; $display("FAIL stall_saved: got %0d want 50", saved); end
    asserts++; if (stall !== 32'(STALL_EXP)) begin fails++; $display("FAIL stall_count: got %0d want %0d", stall, STALL_EXP); end
    asserts++; if (runs !== 8'd2) begin fails++; $display("FAIL stall_runs: got %0d want 2", runs); end
    step_valid = 1'b0;
    repeat (3) tick();
    asserts++; if (busy !== 1'b0 || runs !== 8'd2 || finished !== 1'b1) begin fails++; $display("FAIL no_retrigger: got busy=%0d runs=%0d fin=%0d want 0 2 1", busy, runs, finished); end
    start = 1'b0;
    tick();
  endtask
  task automatic test_abort();
    start = 1'b1;
    step_valid = 1'b1;
    tick();
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    step_valid = 1'b0;
    asserts++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_state: got busy=%0d done=%0d want 0 0", busy, done); end
    asserts++; if (row !== 1'd0 || col !== 2'd2 || inner !== 2'd1) begin fails++; $display("FAIL abort_idx: got %0d %0d %0d want 0 2 1", row, col, inner); end
    asserts++; if (cyc !== 32'd9) begin fails++; $display("FAIL abort_cyc: got %0d want 9", cyc); end
    asserts++; if (runs !== 8'd2 || saved !== 32'd50 || finished !== 1'b0) begin fails++; $display("FAIL abort_keep: got runs=%0d saved=%0d fin=%0d want 2 50 0", runs, saved, finished); end
    repeat (2) tick();
    asserts++; if (busy !== 1'b0 || done !== 1'b0 || inner !== 2'd1) begin fails++; $display("FAIL abort_idle: got busy=%0d done=%0d inner=%0d want 0 0 1", busy, done, inner); end
    start = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid_drain();
    start = 1'b1;
    step_valid = 1'b1;
    tick();
    repeat (24) tick();
    asserts++; if (busy !== 1'b1 || cyc !== 32'd24) begin fails++; $display("FAIL drain_entry: got busy=%0d cyc=%0d want 1 24", busy, cyc); end
    #2 rst = 1'b0;
    #1;
    asserts++; if (busy !== 1'b0 || done !== 1'b0 || finished !== 1'b0) begin fails++; $display("FAIL arst_flags: got busy=%0d done=%0d fin=%0d want 0 0 0", busy, done, finished); end
    asserts++; if (cyc !== 32'd0 || saved !== 32'd0 || runs !== 8'd0 || {row, col, inner} !== 5'd0) begin fails++; $display("FAIL arst_values: got cyc=%0d saved=%0d runs=%0d idx=%0d want 0 0 0 0", cyc, saved, runs, {row, col, inner}); end
    start = 1'b0;
    step_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_idle: got busy=%0d want 0", busy); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_full_run();
    test_stall_pattern();
    test_abort();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
